mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 clock  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU access request; held high until cpu_ack seen.
REQ-006 cpu_we  input  1  CPU access type: 1 = write, 0 = read.
REQ-007 cpu_addr  input  ADDR_W  CPU access address.
REQ-008 cpu_wdata  input  DATA_W  CPU write data.
REQ-009 cpu_ack  output  1  one-cycle CPU completion pulse.
REQ-010 cpu_rdata  output  DATA_W  CPU read data; valid only while cpu_ack=1.
REQ-011 dev_req, dev_we, dev_addr, dev_wdata  input  1/1/ADDR_W/DATA_W  device-port equivalents of REQ-005..008.
REQ-012 dev_ack, dev_rdata  output  1/DATA_W  device-port equivalents of REQ-009..010.
REQ-013 mem_addr  output  ADDR_W  shared single-port memory address.
REQ-014 mem_wdata  output  DATA_W  memory write data.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_re  output  1  memory read enable.
REQ-017 mem_rdata  input  DATA_W  memory read data; valid one cycle after the mem_re cycle.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 States SHALL be IDLE, ACC, ACK; owner register (CPU/DEV) identifies the port being served.
REQ-020 IDLE: no request -> stay IDLE; exactly one request -> ACC for that port; both -> ACC for port not in last_grant register.
REQ-021 On every edge entering ACC, SHALL latch the granted port's we/addr/wdata into internal registers, set owner, and set last_grant = owner.
REQ-022 ACC: mem_addr/mem_wdata driven from latched registers; mem_we = latched we; mem_re = not latched we; next state ACK unconditionally.
REQ-023 Outside ACC, mem_we and mem_re SHALL be 0; mem_addr/mem_wdata SHALL hold their last latched values.
REQ-024 ACK: owner's ack = 1 for exactly this cycle; cpu_rdata and dev_rdata SHALL both equal mem_rdata combinationally.
REQ-025 In ACK, the owner's req SHALL be ignored; if the other port requests -> ACC for it (back-to-back, no IDLE cycle), else -> IDLE.
REQ-026 Latency: request seen in IDLE at edge N -> ACC cycle N+1 -> ack in cycle N+2; requester changes to attributes after the grant edge SHALL NOT affect the access.
REQ-027 Both ports requesting continuously SHALL be served alternately, one ack every 2 cycles; neither port starves.
REQ-028 cpu_ack and dev_ack SHALL never be high in the same cycle; mem_we and mem_re SHALL never be high in the same cycle.
REQ-029 Request withdrawn before grant: no access, no ack; protocol violation only, not detected.

Reset
REQ-030 reset=1 SHALL immediately force: state IDLE, owner CPU, last_grant DEV (CPU wins first tie), mem_addr 0, mem_wdata 0, mem_we 0, mem_re 0, cpu_ack 0, dev_ack 0, busy 0.
REQ-031 Reset during ACC or ACK SHALL abandon the access with no ack; the in-progress write is dropped once mem_we falls.
REQ-032 First request after reset release SHALL follow REQ-026 timing.

Verification
REQ-033 CPU read: mem[0x10]=0x5A, cpu_req=1, cpu_we=0, addr 0x10 at cycle 0 -> cycle 1: mem_re=1, mem_addr=0x10; cycle 2: cpu_ack=1, cpu_rdata=0x5A.
REQ-034 Device write: dev_we=1, addr 0x20, wdata 0xC3 -> cycle 1: mem_we=1, mem_addr=0x20, mem_wdata=0xC3; cycle 2: dev_ack=1; a following CPU read of 0x20 returns 0xC3.
REQ-035 Tie after reset: both req at cycle 0 -> cpu_ack cycle 2, device ACC cycle 3, dev_ack cycle 4, then IDLE.
REQ-036 Both req held for 10 cycles -> acks alternate CPU, DEV, CPU, ..., spaced 2 cycles apart; busy stays 1.
REQ-037 Grant latching: dev_addr changes 0x20 -> 0x7F during ACC -> mem_addr stays 0x20.
REQ-038 Reset pulse mid-ACC of a write -> mem_we=0 and busy=0 within the same cycle; no ack; a later CPU read completes 2 cycles after request.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / device) arbiter in front of one single-port memory.
// Ties go to the port that did not win last; each access takes ACC + ACK.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic              dev_ack,
  output logic [DATA_W-1:0] dev_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic {
    CPU = 1'b0,
    DEV = 1'b1
  } port_t;

  state_t state;
  state_t state_nxt;
  port_t  owner;
  port_t  last_grant;
  port_t  grant;
  logic   grant_vld;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  // In ACK only the other port may be picked up back-to-back.
  always_comb begin
    grant_vld = 1'b0;
    grant     = CPU;
    unique case (state)
      IDLE: begin
        unique case ({cpu_req, dev_req})
          2'b11: begin
            grant_vld = 1'b1;
            grant     = (last_grant == CPU) ? DEV : CPU;
          end
          2'b10: begin
            grant_vld = 1'b1;
            grant     = CPU;
          end
          2'b01: begin
            grant_vld = 1'b1;
            grant     = DEV;
          end
          default: begin
            grant_vld = 1'b0;
            grant     = CPU;
          end
        endcase
      end
      ACK: begin
        if (owner == CPU && dev_req) begin
          grant_vld = 1'b1;
          grant     = DEV;
        end else if (owner == DEV && cpu_req) begin
          grant_vld = 1'b1;
          grant     = CPU;
        end
      end
      default: begin
        grant_vld = 1'b0;
        grant     = CPU;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:    state_nxt = grant_vld ? ACC : IDLE;
      ACC:     state_nxt = ACK;
      ACK:     state_nxt = grant_vld ? ACC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Attributes are captured on the grant edge so later
  // requester changes cannot disturb the access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner      <= CPU;
      last_grant <= DEV;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (state_nxt == ACC) begin
      owner      <= grant;
      last_grant <= grant;
      if (grant == DEV) begin
        lat_we    <= dev_we;
        lat_addr  <= dev_addr;
        lat_wdata <= dev_wdata;
      end else begin
        lat_we    <= cpu_we;
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
      end
    end
  end

  always_comb begin
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    cpu_ack = 1'b0;
    dev_ack = 1'b0;
    unique case (state)
      ACC: begin
        mem_we = lat_we;
        mem_re = ~lat_we;
      end
      ACK: begin
        cpu_ack = (owner == CPU);
        dev_ack = (owner == DEV);
      end
      default: begin
        mem_we  = 1'b0;
        mem_re  = 1'b0;
      end
    endcase
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_rdata = mem_rdata;
  assign dev_rdata = mem_rdata;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, per-port scoreboards,
// and cycle-accurate checks of grant, latency and reset behaviour.
module tb_mem_arbiter;

  logic       clock;
  logic       reset;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       dev_req;
  logic       dev_we;
  logic [7:0] dev_addr;
  logic [7:0] dev_wdata;
  logic       dev_ack;
  logic [7:0] dev_rdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       busy;

  typedef struct packed {
    logic       we;
    logic [7:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t dev_q[$];
  exp_t ce;
  exp_t de;

  logic [7:0] mem  [256];
  logic [7:0] refm [256];
  logic [7:0] old_val;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dev_req   (dev_req),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_ack   (dev_ack),
    .dev_rdata (dev_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-port memory, read data registered one cycle after mem_re.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h10] = 8'h5A;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clock);
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge clock) begin
    if (cpu_ack) begin
      if (cpu_q.size() == 0) chk("cpu_ack_unexp", 1, 0);
      else begin
        ce = cpu_q.pop_front();
        if (!ce.we) chk("cpu_rdata_sb", cpu_rdata, ce.data);
      end
    end
    if (dev_ack) begin
      if (dev_q.size() == 0) chk("dev_ack_unexp", 1, 0);
      else begin
        de = dev_q.pop_front();
        if (!de.we) chk("dev_rdata_sb", dev_rdata, de.data);
      end
    end
    if (cpu_ack | dev_ack) chk("ack_excl", cpu_ack & dev_ack, 0);
    if (mem_we | mem_re) chk("we_re_excl", mem_we & mem_re, 0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_go(input logic we, input logic [7:0] a,
                        input logic [7:0] d);
    exp_t x;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    x.we   = we;
    x.data = refm[a];
    cpu_q.push_back(x);
    if (we) refm[a] = d;
  endtask

  task automatic dev_go(input logic we, input logic [7:0] a,
                        input logic [7:0] d);
    exp_t x;
    dev_req   = 1'b1;
    dev_we    = we;
    dev_addr  = a;
    dev_wdata = d;
    x.we   = we;
    x.data = refm[a];
    dev_q.push_back(x);
    if (we) refm[a] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refm[i] = 8'(i) ^ 8'hA5;
    refm[8'h10] = 8'h5A;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dev_req = 0; dev_we = 0; dev_addr = 0; dev_wdata = 0;
    #3;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dev_ack", dev_ack, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    reset = 1'b0;

    // CPU read of a preloaded location
    cpu_go(1'b0, 8'h10, 8'h00);
    tick();
    chk("rd_mem_re", mem_re, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 8'h10);
    chk("rd_busy", busy, 1);
    chk("rd_early_ack", cpu_ack, 0);
    tick();
    chk("rd_cpu_ack", cpu_ack, 1);
    chk("rd_cpu_rdata", cpu_rdata, 8'h5A);
    chk("rd_re_off", mem_re, 0);
    chk("rd_addr_hold", mem_addr, 8'h10);
    cpu_req = 1'b0;
    tick();
    chk("rd_idle", busy, 0);

    // Device write, then back-to-back CPU read of it
    dev_go(1'b1, 8'h20, 8'hC3);
    tick();
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_re", mem_re, 0);
    chk("wr_mem_addr", mem_addr, 8'h20);
    chk("wr_mem_wdata", mem_wdata, 8'hC3);
    tick();
    chk("wr_dev_ack", dev_ack, 1);
    chk("wr_cpu_ack", cpu_ack, 0);
    chk("wr_we_off", mem_we, 0);
    dev_req = 1'b0;
    cpu_go(1'b0, 8'h20, 8'h00);
    tick();
    chk("b2b_mem_re", mem_re, 1);
    chk("b2b_addr", mem_addr, 8'h20);
    tick();
    chk("b2b_cpu_ack", cpu_ack, 1);
    chk("b2b_rdata", cpu_rdata, 8'hC3);
    cpu_req = 1'b0;
    tick();
    chk("b2b_idle", busy, 0);

    // Attribute change after grant must not leak into the access
    dev_go(1'b0, 8'h20, 8'h00);
    tick();
    dev_addr = 8'h7F;
    #1;
    chk("latch_addr", mem_addr, 8'h20);
    tick();
    chk("latch_ack", dev_ack, 1);
    chk("latch_rdata", dev_rdata, 8'hC3);
    dev_req = 1'b0;
    tick();

    // Tie right after reset goes to the CPU first
    do_reset();
    cpu_go(1'b0, 8'h40, 8'h00);
    dev_go(1'b0, 8'h41, 8'h00);
    tick();
    chk("tie_c1_addr", mem_addr, 8'h40);
    tick();
    chk("tie_c2_cpu", cpu_ack, 1);
    chk("tie_c2_dev", dev_ack, 0);
    cpu_req = 1'b0;
    tick();
    chk("tie_c3_re", mem_re, 1);
    chk("tie_c3_addr", mem_addr, 8'h41);
    tick();
    chk("tie_c4_dev", dev_ack, 1);
    dev_req = 1'b0;
    tick();
    chk("tie_idle", busy, 0);

    // Continuous requests from both ports alternate
    do_reset();
    cpu_go(1'b0, 8'h50, 8'h00);
    dev_go(1'b0, 8'h51, 8'h00);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c <= 12) chk("alt_busy", busy, 1);
      else chk("alt_idle", busy, 0);
      chk("alt_cpu_ack", cpu_ack, (c == 2 || c == 6 || c == 10));
      chk("alt_dev_ack", dev_ack, (c == 4 || c == 8 || c == 12));
      if (c == 2 || c == 6) cpu_go(1'b0, 8'h50, 8'h00);
      if (c == 10) cpu_req = 1'b0;
      if (c == 4 || c == 8) dev_go(1'b0, 8'h51, 8'h00);
      if (c == 12) dev_req = 1'b0;
    end

    // Reset in the middle of a write drops it
    old_val = refm[8'h30];
    dev_go(1'b1, 8'h30, 8'h99);
    tick();
    chk("rw_mem_we", mem_we, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_we_drop", mem_we, 0);
    chk("rw_busy_drop", busy, 0);
    chk("rw_addr_clr", mem_addr, 0);
    dev_req = 1'b0;
    dev_q.delete();
    refm[8'h30] = old_val;
    tick();
    chk("rw_no_dev_ack", dev_ack, 0);
    chk("rw_busy_rst", busy, 0);
    reset = 1'b0;
    cpu_go(1'b0, 8'h30, 8'h00);
    tick();
    chk("rw_c1_re", mem_re, 1);
    chk("rw_c1_addr", mem_addr, 8'h30);
    tick();
    chk("rw_c2_ack", cpu_ack, 1);
    chk("rw_c2_rdata", cpu_rdata, 8'h95);
    chk("rw_c2_dev_ack", dev_ack, 0);
    cpu_req = 1'b0;
    tick();
    tick();

    chk("cpu_q_left", cpu_q.size(), 0);
    chk("dev_q_left", dev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
